// File: rtl/text_pkg.sv
// Shared constants and sideband record for the text-mode pixel pipeline.
package text_pkg;

  localparam int CHAR_W   = 8;
  localparam int CHAR_H   = 16;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COLS     = H_ACTIVE / CHAR_W;
  localparam int ROWS     = V_ACTIVE / CHAR_H;

  typedef struct packed {
    logic [9:0] draw_x;
    logic [9:0] draw_y;
    logic       hs;
    logic       vs;
    logic       vde;
  } sideband_t;

  // Syncs are active-low, so their idle (reset) level is 1.
  localparam sideband_t SIDEBAND_RST = '{draw_x: 10'd0, draw_y: 10'd0,
                                         hs: 1'b1, vs: 1'b1, vde: 1'b0};

  // Linear cell index row*80 + col, built from shifts instead of a multiplier.
  function automatic logic [11:0] cell_index(input logic [9:0] x, input logic [9:0] y);
    logic [5:0] row;
    logic [6:0] col;
    row = y[9:4];
    col = x[9:3];
    return {row, 6'b0} + {2'b0, row, 4'b0} + {5'b0, col};
  endfunction

endpackage

// File: rtl/text_vram_fetch_if.sv
// Text-VRAM read port: combinational address out, data back one cycle later.
interface text_vram_fetch_if #(parameter int ADDR_W = 10);

  logic [ADDR_W-1:0] vram_addr;
  logic [31:0]       vram_rdata;

  modport master (output vram_addr, input vram_rdata);
  modport slave  (input vram_addr, output vram_rdata);

endinterface

// File: rtl/text_pipe_delay.sv
// N-stage shift register for the pixel sideband; syncs reset high, rest low.
module text_pipe_delay
  import text_pkg::*;
#(
  parameter int N = 2
) (
  input  logic      pixel_clk,
  input  logic      reset,
  input  sideband_t d,
  output sideband_t q
);

  sideband_t stages [N];

  // NOTE: sequential state uses non-blocking (<=) so every stage samples the
  // pre-edge value of its predecessor; blocking here would collapse the chain.
  // NOTE: this array is a handful of flops, not a RAM, so resetting it is cheap
  // and keeps the syncs idle-high straight out of reset.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) stages[i] <= SIDEBAND_RST;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < N; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = stages[N-1];

endmodule

// File: rtl/text_vram_fetch.sv
// Text VRAM fetch stage: cell address decode, glyph byte select, sideband alignment.
// Optional blinking cursor enabled by defining TEXT_CURSOR_EN.
module text_vram_fetch
  import text_pkg::*;
#(
  parameter int COLS   = text_pkg::COLS,
  parameter int ROWS   = text_pkg::ROWS,
  parameter int ADDR_W = 10
) (
  input  logic                     pixel_clk,
  input  logic                     reset,
  input  logic [9:0]               draw_x,
  input  logic [9:0]               draw_y,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic                     vde_in,
  input  logic [31:0]              ctrl_reg_in,
  text_vram_fetch_if.master        vram,
`ifdef TEXT_CURSOR_EN
  input  logic [11:0]              cursor_idx,
`endif
  output logic [9:0]               draw_x_o,
  output logic [9:0]               draw_y_o,
  output logic                     hsync_o,
  output logic                     vsync_o,
  output logic                     vde_o,
  output logic [7:0]               code,
  output logic [31:0]              control
);

  localparam logic [9:0] X_LIMIT = 10'(COLS * CHAR_W);
  localparam logic [9:0] Y_LIMIT = 10'(ROWS * CHAR_H);

  logic [11:0] lin;
  logic        oor;
  logic        oor_q;
  logic [1:0]  sel;
  logic [7:0]  rd_byte;
  logic [7:0]  code_d;
  logic        vs_q;
  logic        sync_start;
  sideband_t   sb_in;
  sideband_t   sb_out;

  // NOTE: every signal written in an always_comb gets a value before any
  // conditional, otherwise a path that skips the assignment infers a latch.
  always_comb begin
    lin            = cell_index(draw_x, draw_y);
    oor            = (draw_x >= X_LIMIT) || (draw_y >= Y_LIMIT);
    vram.vram_addr = oor ? '0 : ADDR_W'(lin[11:2]);
  end

`ifdef TEXT_CURSOR_EN
  logic [11:0] lin_q;
  logic [5:0]  frame_cnt;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      lin_q <= '0;
      oor_q <= 1'b1;
    end else begin
      lin_q <= lin;
      oor_q <= oor;
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset)           frame_cnt <= '0;
    else if (sync_start) frame_cnt <= frame_cnt + 6'd1;
  end

  assign sel = lin_q[1:0];
`else
  logic [1:0] sel_q;

  // oor_q resets high so code stays 0 until real pixels reach stage 2.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      sel_q <= '0;
      oor_q <= 1'b1;
    end else begin
      sel_q <= lin[1:0];
      oor_q <= oor;
    end
  end

  assign sel = sel_q;
`endif

  assign rd_byte = vram.vram_rdata[{sel, 3'b000} +: 8];

  always_comb begin
    code_d = oor_q ? 8'h00 : rd_byte;
`ifdef TEXT_CURSOR_EN
    if (!oor_q && (lin_q == cursor_idx) && !frame_cnt[5]) code_d[7] = ~code_d[7];
`endif
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) code <= 8'h00;
    else       code <= code_d;
  end

  // Control is only sampled at vsync start so a mid-frame write cannot tear.
  assign sync_start = vs_q && !vsync_in;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      vs_q    <= 1'b1;
      control <= '0;
    end else begin
      vs_q <= vsync_in;
      if (sync_start) control <= ctrl_reg_in;
    end
  end

  assign sb_in = '{draw_x: draw_x, draw_y: draw_y, hs: hsync_in, vs: vsync_in, vde: vde_in};

  text_pipe_delay #(.N(2)) u_sideband_delay (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .d         (sb_in),
    .q         (sb_out)
  );

  assign draw_x_o = sb_out.draw_x;
  assign draw_y_o = sb_out.draw_y;
  assign hsync_o  = sb_out.hs;
  assign vsync_o  = sb_out.vs;
  assign vde_o    = sb_out.vde;

endmodule

// File: tb/tb_text_vram_fetch.sv
// Self-checking bench for text_vram_fetch against a 2-cycle-latency behavioural model.
module tb_text_vram_fetch;
  import text_pkg::*;

`ifdef TEXT_CURSOR_EN
  localparam bit CURSOR_EN = 1'b1;
`else
  localparam bit CURSOR_EN = 1'b0;
`endif

  logic        pixel_clk = 1'b0;
  logic        reset;
  logic [9:0]  draw_x, draw_y;
  logic        hsync_in, vsync_in, vde_in;
  logic [31:0] ctrl_reg_in;
  logic [11:0] cursor_idx;
  logic [9:0]  draw_x_o, draw_y_o;
  logic        hsync_o, vsync_o, vde_o;
  logic [7:0]  code;
  logic [31:0] control;

  text_vram_fetch_if #(.ADDR_W(10)) vram ();

  logic        use_ram;
  logic [31:0] rdata_drv;
  logic [31:0] ram_q;
  logic [31:0] mem [600];

  assign vram.vram_rdata = use_ram ? ram_q : rdata_drv;
  always @(posedge pixel_clk) ram_q <= (vram.vram_addr < 10'd600) ? mem[vram.vram_addr] : 32'h0;

  always #5 pixel_clk = ~pixel_clk;

  text_vram_fetch dut (
    .pixel_clk   (pixel_clk),
    .reset       (reset),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .vde_in      (vde_in),
    .ctrl_reg_in (ctrl_reg_in),
    .vram        (vram.master),
`ifdef TEXT_CURSOR_EN
    .cursor_idx  (cursor_idx),
`endif
    .draw_x_o    (draw_x_o),
    .draw_y_o    (draw_y_o),
    .hsync_o     (hsync_o),
    .vsync_o     (vsync_o),
    .vde_o       (vde_o),
    .code        (code),
    .control     (control)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: one pixel in flight between input and output.
  typedef struct {
    logic [9:0] x, y;
    logic       hs, vs, vde;
    bit         oor;
    int         lin;
  } pix_t;

  pix_t        pend;
  int          frames;
  logic        prev_vs;
  logic [31:0] exp_ctrl;
  logic [7:0]  e_code;
  logic [9:0]  e_x, e_y;
  logic        e_hs, e_vs, e_vde;

  task automatic model_reset();
    pend     = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, vde: 1'b0, oor: 1'b1, lin: 0};
    frames   = 0;
    prev_vs  = 1'b1;
    exp_ctrl = 32'h0;
  endtask

  task automatic check_outputs(input string sfx);
    check({"code", sfx},     {24'h0, code},     {24'h0, e_code});
    check({"draw_x_o", sfx}, {22'h0, draw_x_o}, {22'h0, e_x});
    check({"draw_y_o", sfx}, {22'h0, draw_y_o}, {22'h0, e_y});
    check({"hsync_o", sfx},  {31'h0, hsync_o},  {31'h0, e_hs});
    check({"vsync_o", sfx},  {31'h0, vsync_o},  {31'h0, e_vs});
    check({"vde_o", sfx},    {31'h0, vde_o},    {31'h0, e_vde});
    check({"control", sfx},  control,           exp_ctrl);
  endtask

  // One pixel per cycle: drive, check address, clock, check the pixel from one step earlier.
  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic hs,
                      input logic vs, input logic vde, input logic [31:0] ctrl);
    int          lin;
    bit          oor;
    logic [31:0] word;
    draw_x = x; draw_y = y; hsync_in = hs; vsync_in = vs; vde_in = vde; ctrl_reg_in = ctrl;
    #1;
    lin = (int'(y) / 16) * 80 + int'(x) / 8;
    oor = (x >= 10'd640) || (y >= 10'd480);
    check("vram_addr", {22'h0, vram.vram_addr}, oor ? 32'h0 : 32'(lin / 4));

    word   = pend.oor ? 32'h0 : (use_ram ? mem[pend.lin / 4] : rdata_drv);
    e_code = pend.oor ? 8'h00 : 8'(word >> (8 * (pend.lin % 4)));
    if (CURSOR_EN && !pend.oor && pend.lin == int'(cursor_idx) && (frames % 64) < 32)
      e_code = e_code ^ 8'h80;
    e_x = pend.x; e_y = pend.y; e_hs = pend.hs; e_vs = pend.vs; e_vde = pend.vde;
    if (prev_vs && !vs) begin
      frames++;
      exp_ctrl = ctrl;
    end
    prev_vs = vs;
    pend = '{x: x, y: y, hs: hs, vs: vs, vde: vde, oor: oor, lin: lin};

    @(posedge pixel_clk);
    #1;
    check_outputs("");
  endtask

  initial begin
    use_ram = 1'b0; rdata_drv = 32'h0; cursor_idx = 12'd81;
    for (int i = 0; i < 600; i++) mem[i] = $urandom;
    reset = 1'b1;
    draw_x = '0; draw_y = '0; hsync_in = 1'b1; vsync_in = 1'b1; vde_in = 1'b0; ctrl_reg_in = '0;
    model_reset();
    e_code = 8'h00; e_x = '0; e_y = '0; e_hs = 1'b1; e_vs = 1'b1; e_vde = 1'b0;
    repeat (2) @(posedge pixel_clk);
    #1;
    check_outputs("_rst");
    reset = 1'b0;

    // Control latch: mid-frame change ignored, taken at vsync start.
    step(10'd100, 10'd20, 1'b1, 1'b1, 1'b1, 32'h0);
    step(10'd101, 10'd20, 1'b1, 1'b1, 1'b1, 32'h01FFE000);
    step(10'd102, 10'd20, 1'b1, 1'b1, 1'b1, 32'h01FFE000);
    step(10'd103, 10'd20, 1'b1, 1'b0, 1'b1, 32'h01FFE000);
    step(10'd104, 10'd20, 1'b1, 1'b0, 1'b1, 32'h12345678);
    check("control_latched", control, 32'h01FFE000);

    // Byte lanes within word 0.
    rdata_drv = 32'h44332211;
    step(10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 32'h0);
    step(10'd7,  10'd0, 1'b1, 1'b1, 1'b1, 32'h0);
    step(10'd8,  10'd0, 1'b1, 1'b1, 1'b1, 32'h0);
    step(10'd24, 10'd0, 1'b1, 1'b1, 1'b1, 32'h0);
    step(10'd26, 10'd0, 1'b1, 1'b1, 1'b1, 32'h0);
    check("lane3_code", {24'h0, code}, 32'h44);

    // Last cell: address 599, byte 3 of the word returned next cycle.
    step(10'd632, 10'd464, 1'b0, 1'b1, 1'b1, 32'h0);
    rdata_drv = 32'hAB000000;
    step(10'd639, 10'd479, 1'b1, 1'b1, 1'b1, 32'h0);
    step(10'd640, 10'd479, 1'b1, 1'b1, 1'b0, 32'h0);
    check("last_cell_code", {24'h0, code}, 32'hAB);

    // Blanking: out-of-range pixels read address 0 and produce code 0.
    rdata_drv = 32'hFFFFFFFF;
    step(10'd700, 10'd10,  1'b0, 1'b1, 1'b0, 32'h0);
    step(10'd700, 10'd10,  1'b0, 1'b1, 1'b1, 32'h0);
    step(10'd10,  10'd500, 1'b1, 1'b1, 1'b0, 32'h0);
    step(10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 32'h0);

    // Reset mid-line at x=300: outputs clear immediately, then track after release.
    rdata_drv = 32'h5A5A5A5A;
    step(10'd298, 10'd100, 1'b1, 1'b1, 1'b1, 32'h0);
    step(10'd299, 10'd100, 1'b1, 1'b1, 1'b1, 32'h0);
    draw_x = 10'd300;
    reset = 1'b1;
    #1;
    model_reset();
    e_code = 8'h00; e_x = '0; e_y = '0; e_hs = 1'b1; e_vs = 1'b1; e_vde = 1'b0;
    check_outputs("_midrst");
    @(posedge pixel_clk);
    #1;
    reset = 1'b0;
    step(10'd301, 10'd100, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D);
    step(10'd302, 10'd100, 1'b1, 1'b1, 1'b1, 32'hCAFEF00D);
    step(10'd303, 10'd100, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D);
    step(10'd304, 10'd100, 1'b1, 1'b0, 1'b1, 32'h0);

    // Randomised pixels against a random VRAM image.
    use_ram = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step(10'($urandom_range(799, 0)), 10'($urandom_range(524, 0)),
           1'($urandom), ($urandom_range(15, 0) != 0) ? 1'b1 : 1'b0,
           1'($urandom), $urandom);
    end

    // Cursor blink over more than 64 frames at cell 81 (x=8, y=16).
    use_ram   = 1'b0;
    rdata_drv = 32'h00004100;
    for (int f = 0; f < 70; f++) begin
      step(10'd8, 10'd16, 1'b1, 1'b1, 1'b1, 32'h0);
      step(10'd8, 10'd16, 1'b1, 1'b0, 1'b1, 32'h0);
      step(10'd8, 10'd16, 1'b1, 1'b0, 1'b1, 32'h0);
      step(10'd16, 10'd16, 1'b1, 1'b1, 1'b1, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
